// File: rtl/radix4_online_serializer_pkg.sv
// Shared definitions for the radix-4 online arithmetic units:
// signed-digit encodings, default digit width and serializer states.
package online_arith_pkg;

    localparam int RADIX_BITS_DEF = 3;

    localparam logic [2:0] DIGIT_ZERO = 3'b000;
    localparam logic [2:0] DIGIT_P1   = 3'b001;
    localparam logic [2:0] DIGIT_P2   = 3'b010;
    localparam logic [2:0] DIGIT_M1   = 3'b111;
    localparam logic [2:0] DIGIT_M2   = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_PAD  = 2'd2
    } ser_state_e;

    // grp = {I[2k+1], I[2k], I[2k-1]}
    function automatic logic [2:0] booth_digit(
        input logic [2:0] grp
    );
        logic [2:0] d;
        d = DIGIT_ZERO;
        case (grp)
            3'b000:  d = DIGIT_ZERO;
            3'b001:  d = DIGIT_P1;
            3'b010:  d = DIGIT_P1;
            3'b011:  d = DIGIT_P2;
            3'b100:  d = DIGIT_M2;
            3'b101:  d = DIGIT_M1;
            3'b110:  d = DIGIT_M1;
            default: d = DIGIT_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/radix4_online_serializer_if.sv
// Operand-in / digit-out handshake bundle of the serializer.
// The slave modport is the serializer side.
interface radix4_online_serializer_if
    import online_arith_pkg::*;
#(
    parameter int NO_OF_DIGITS = 4,
    parameter int RADIX_BITS   = RADIX_BITS_DEF
);

    logic                      in_valid;
    logic                      in_ready;
    logic [2*NO_OF_DIGITS-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [RADIX_BITS-1:0]     out_digit;
    logic                      out_first;
    logic                      out_last;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_digit,
        input  out_first,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_digit,
        output out_first,
        output out_last
    );

endinterface

// File: rtl/radix4_online_serializer_recoder.sv
// Combinational Booth radix-4 recoder: two's-complement operand in,
// signed digits {-2..2} out, most-significant digit in the top field.
module booth_radix4_recoder
    import online_arith_pkg::*;
#(
    parameter int NO_OF_DIGITS = 4,
    parameter int RADIX_BITS   = RADIX_BITS_DEF
) (
    input  logic [2*NO_OF_DIGITS-1:0]          operand,
    output logic [NO_OF_DIGITS*RADIX_BITS-1:0] digits
);

    // Append the implicit I[-1] = 0 below the LSB.
    logic [2*NO_OF_DIGITS:0] ext;

    assign ext = {operand, 1'b0};

    for (genvar k = 0; k < NO_OF_DIGITS; k++) begin : g_dig
        assign digits[k*RADIX_BITS +: RADIX_BITS] =
            RADIX_BITS'($signed(booth_digit(ext[2*k +: 3])));
    end

endmodule

// File: rtl/radix4_online_serializer.sv
// Radix-4 online serializer: recodes one operand per transaction and
// streams its digits MSD first, followed by PAD_DIGITS zero digits.
module radix4_online_serializer
    import online_arith_pkg::*;
#(
    parameter int NO_OF_DIGITS = 4,
    parameter int RADIX_BITS   = RADIX_BITS_DEF,
    parameter int PAD_DIGITS   = 2
) (
    input logic                        clk,
    input logic                        reset,
    radix4_online_serializer_if.slave  bus
);

    localparam int TOTAL = NO_OF_DIGITS + PAD_DIGITS;
    localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int VW    = NO_OF_DIGITS * RADIX_BITS;

    localparam logic [CW-1:0] LSD_CNT = CW'(NO_OF_DIGITS - 1);
    localparam logic [CW-1:0] END_CNT = CW'(TOTAL - 1);

    localparam logic PAD_EN   = (PAD_DIGITS > 0);
    localparam logic ONE_PAD  = (PAD_DIGITS == 1);
    localparam logic ONE_BEAT = (TOTAL == 1);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] SEND = ST_SEND;
    localparam logic [1:0] PAD  = ST_PAD;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_inc;
    logic [VW-1:0]         rec_vec;
    logic [VW-1:0]         sh;
    logic                  out_valid_q;
    logic [RADIX_BITS-1:0] out_digit_q;
    logic                  out_first_q;
    logic                  out_last_q;
    logic                  beat;

    booth_radix4_recoder #(
        .NO_OF_DIGITS (NO_OF_DIGITS),
        .RADIX_BITS   (RADIX_BITS)
    ) u_recoder (
        .operand (bus.in_data),
        .digits  (rec_vec)
    );

    assign cnt_inc = cnt + 1'b1;
    assign beat    = out_valid_q && bus.out_ready;

    // sh holds the digits not yet loaded into out_digit, next one on top.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sh          <= '0;
            out_valid_q <= 1'b0;
            out_digit_q <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state       <= SEND;
                        cnt         <= '0;
                        sh          <= rec_vec << RADIX_BITS;
                        out_valid_q <= 1'b1;
                        out_digit_q <= rec_vec[VW-1 -: RADIX_BITS];
                        out_first_q <= 1'b1;
                        out_last_q  <= ONE_BEAT;
                    end
                end
                SEND: begin
                    if (beat) begin
                        out_first_q <= 1'b0;
                        if (cnt == LSD_CNT) begin
                            out_digit_q <= '0;
                            if (PAD_EN) begin
                                state      <= PAD;
                                cnt        <= cnt_inc;
                                out_last_q <= ONE_PAD;
                            end else begin
                                state       <= IDLE;
                                cnt         <= '0;
                                out_valid_q <= 1'b0;
                                out_last_q  <= 1'b0;
                            end
                        end else begin
                            cnt         <= cnt_inc;
                            sh          <= sh << RADIX_BITS;
                            out_digit_q <= sh[VW-1 -: RADIX_BITS];
                            out_last_q  <= !PAD_EN
                                        && (cnt_inc == LSD_CNT);
                        end
                    end
                end
                PAD: begin
                    if (beat) begin
                        if (cnt == END_CNT) begin
                            state       <= IDLE;
                            cnt         <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            cnt        <= cnt_inc;
                            out_last_q <= (cnt_inc == END_CNT);
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    out_valid_q <= 1'b0;
                    out_digit_q <= '0;
                    out_first_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = out_valid_q;
    assign bus.out_digit = out_digit_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_radix4_online_serializer.sv
// Directed and scoreboard checks of radix4_online_serializer with
// PAD_DIGITS=2 (dut_a) and PAD_DIGITS=0 (dut_b).
module tb_radix4_online_serializer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    radix4_online_serializer_if #(.NO_OF_DIGITS(4), .RADIX_BITS(3)) ba ();
    radix4_online_serializer_if #(.NO_OF_DIGITS(4), .RADIX_BITS(3)) bb ();

    radix4_online_serializer #(
        .NO_OF_DIGITS (4),
        .RADIX_BITS   (3),
        .PAD_DIGITS   (2)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ba.slave)
    );

    radix4_online_serializer #(
        .NO_OF_DIGITS (4),
        .RADIX_BITS   (3),
        .PAD_DIGITS   (0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bb.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  data;
        logic [17:0] digs;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic run_op(input logic [7:0] data, input logic [17:0] digs,
                          input logic [31:0] stall, input int pulse_at,
                          input int exp_cycles);
        int beat;
        int c;
        chk("in_ready_idle", 32'(ba.in_ready), 1);
        ba.in_valid  = 1'b1;
        ba.in_data   = data;
        ba.out_ready = 1'b1;
        @(negedge clk);
        ba.in_valid = 1'b0;
        beat = 0;
        c    = 0;
        while (beat < 6 && c < 40) begin
            ba.out_ready = (c < 32) ? !stall[c] : 1'b1;
            if (c == pulse_at) begin
                ba.in_valid = 1'b1;
                ba.in_data  = 8'h11;
            end else begin
                ba.in_valid = 1'b0;
            end
            chk("out_valid", 32'(ba.out_valid), 1);
            chk("in_ready_busy", 32'(ba.in_ready), 0);
            chk("digit", 32'(ba.out_digit), 32'(digs[17-3*beat -: 3]));
            chk("first", 32'(ba.out_first), 32'(beat == 0));
            chk("last", 32'(ba.out_last), 32'(beat == 5));
            if (ba.out_ready) beat++;
            c++;
            @(negedge clk);
        end
        ba.in_valid  = 1'b0;
        ba.out_ready = 1'b1;
        chk("beat_cycles", 32'(c), 32'(exp_cycles));
        chk("in_ready_after", 32'(ba.in_ready), 1);
        chk("out_valid_after", 32'(ba.out_valid), 0);
    endtask

    task automatic random_b();
        logic [7:0] q[$];
        logic [7:0] cur;
        logic [7:0] expv;
        int acc;
        int nb;
        int sent;
        int done;
        int cyc;
        logic legal;
        acc  = 0;
        nb   = 0;
        sent = 0;
        done = 0;
        cyc  = 0;
        cur  = 8'($urandom);
        while (done < 1000 && cyc < 40000) begin
            bb.out_ready = 1'($urandom_range(0, 1));
            if (bb.out_valid && bb.out_ready) begin
                legal = (bb.out_digit != 3'b011) && (bb.out_digit != 3'b100)
                     && (bb.out_digit != 3'b101);
                chk("b_digit_legal", 32'(legal), 1);
                chk("b_first", 32'(bb.out_first), 32'(nb == 0));
                if (bb.out_first) begin
                    acc = 0;
                    nb  = 0;
                end
                acc = acc * 4 + int'($signed(bb.out_digit));
                nb++;
                if (bb.out_last) begin
                    chk("b_last_on_lsd", 32'(nb), 4);
                    if (q.size() > 0) begin
                        expv = q.pop_front();
                        chk("b_value", 32'(acc), 32'(int'($signed(expv))));
                    end else begin
                        chk("b_queue_nonempty", 0, 1);
                    end
                    nb = 0;
                    done++;
                end
            end
            if (sent < 1000) begin
                bb.in_valid = 1'b1;
                bb.in_data  = cur;
                if (bb.in_ready) begin
                    q.push_back(cur);
                    sent++;
                    cur = 8'($urandom);
                end
            end else begin
                bb.in_valid = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        bb.in_valid  = 1'b0;
        bb.out_ready = 1'b0;
        chk("b_ops_done", 32'(done), 1000);
    endtask

    initial begin
        vecs[0] = '{8'h5A, {3'b001, 3'b010, 3'b111, 3'b110, 3'b000, 3'b000}};
        vecs[1] = '{8'h80, {3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000}};
        vecs[2] = '{8'hFF, {3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000}};
        vecs[3] = '{8'h01, {3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000}};
        vecs[4] = '{8'h7F, {3'b010, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000}};
        vecs[5] = '{8'h00, {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000}};

        reset        = 1'b1;
        ba.in_valid  = 1'b1;
        ba.in_data   = 8'h5A;
        ba.out_ready = 1'b1;
        bb.in_valid  = 1'b0;
        bb.in_data   = 8'h00;
        bb.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(ba.out_valid), 0);
        chk("rst_out_digit", 32'(ba.out_digit), 0);
        chk("rst_out_first", 32'(ba.out_first), 0);
        chk("rst_out_last", 32'(ba.out_last), 0);
        chk("rst_in_ready", 32'(ba.in_ready), 0);
        reset       = 1'b0;
        ba.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(ba.out_valid), 0);
        chk("post_rst_ready", 32'(ba.in_ready), 1);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].data, vecs[i].digs, 32'h0, -1, 6);
        end

        run_op(vecs[0].data, vecs[0].digs, 32'h0000_000E, -1, 9);

        run_op(vecs[0].data, vecs[0].digs, 32'h0, 2, 6);
        @(negedge clk);
        chk("ignored_not_sent", 32'(ba.out_valid), 0);

        ba.in_valid  = 1'b1;
        ba.in_data   = 8'h5A;
        ba.out_ready = 1'b1;
        @(negedge clk);
        ba.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_beat3", 32'(ba.out_digit), 32'(3'b111));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(ba.out_valid), 0);
        chk("mid_rst_digit", 32'(ba.out_digit), 0);
        chk("mid_rst_last", 32'(ba.out_last), 0);
        chk("mid_rst_ready", 32'(ba.in_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rel_ready", 32'(ba.in_ready), 1);
        chk("mid_rel_valid", 32'(ba.out_valid), 0);
        run_op(vecs[3].data, vecs[3].digs, 32'h0, -1, 6);

        random_b();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
